// File: rtl/weight_fifo_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : weight_fifo_loader
//  Purpose  : Write side of the weight FIFO. Accepts tile-load commands,
//             issues FIFO_WIDTH row reads to weight memory, forwards each
//             returned row into the weight FIFO, and tracks resident tiles
//             together with a per-tile stagger flag for the drain side.
//  Revision : 1.0  initial release
// ============================================================================
module weight_fifo_loader #(
    parameter int FIFO_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_TILES = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [ADDR_WIDTH-1:0]                cmd_addr,
    input  logic                                 cmd_stagger,
    output logic                                 mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    input  logic                                 mem_rd_valid,
    input  logic [FIFO_WIDTH*DATA_WIDTH-1:0]     mem_rd_data,
    output logic                                 fifo_push,
    output logic [FIFO_WIDTH*DATA_WIDTH-1:0]     fifo_data,
    output logic                                 tile_ready,
    output logic                                 head_stagger,
    input  logic                                 tile_consumed,
    output logic [$clog2(DEPTH_TILES+1)-1:0]     tiles_avail,
    output logic                                 busy,
    output logic [1:0]                           err
);

    localparam int ROW_W  = FIFO_WIDTH * DATA_WIDTH;
    localparam int CNT_W  = $clog2(FIFO_WIDTH + 1);
    localparam int TILE_W = $clog2(DEPTH_TILES + 1);
    localparam int PTR_W  = $clog2(DEPTH_TILES);

    localparam logic [CNT_W-1:0]  LAST_ISSUE = CNT_W'(FIFO_WIDTH - 1);
    localparam logic [CNT_W-1:0]  ROWS       = CNT_W'(FIFO_WIDTH);
    localparam logic [TILE_W-1:0] MAX_TILES  = TILE_W'(DEPTH_TILES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     stagger_q, stagger_d;
    logic [CNT_W-1:0]         issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]         rx_cnt_q, rx_cnt_d;
    logic                     push_q, push_d;
    logic [ROW_W-1:0]         data_q, data_d;
    logic [TILE_W-1:0]        tiles_q, tiles_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DEPTH_TILES-1:0]   queue_q;
    logic [1:0]               err_q, err_d;
    logic                     ready_q, ready_d;

    logic                     rx_ok;
    logic                     complete;
    logic                     consume_ok;

    // Row acceptance, tile completion and consumption qualifiers
    always_comb begin
        rx_ok      = mem_rd_valid && (state_q != S_IDLE) && (rx_cnt_q < ROWS);
        complete   = (state_q == S_DRAIN) && (rx_cnt_q == ROWS);
        consume_ok = tile_consumed && (tiles_q != '0);
    end

    // Next-state logic: load FSM, row forwarding, tile accounting, errors
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stagger_d   = stagger_q;
        issue_cnt_d = issue_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        push_d      = rx_ok;
        data_d      = data_q;
        tiles_d     = tiles_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_d       = err_q;

        if (rx_ok) begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
            data_d   = mem_rd_data;
        end
        // Rows arriving while idle or after the tile is full are dropped
        if (mem_rd_valid && !rx_ok) begin
            err_d[1] = 1'b1;
        end
        if (tile_consumed && (tiles_q == '0)) begin
            err_d[0] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    addr_d      = cmd_addr;
                    stagger_d   = cmd_stagger;
                    issue_cnt_d = '0;
                    rx_cnt_d    = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_cnt_q == LAST_ISSUE) begin
                    state_d = S_DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (complete) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (consume_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // A completion and a consume in the same cycle cancel out
        case ({complete, consume_ok})
            2'b10:   tiles_d = tiles_q + TILE_W'(1);
            2'b01:   tiles_d = tiles_q - TILE_W'(1);
            default: tiles_d = tiles_q;
        endcase

        // Registered so that cmd_ready is low throughout reset
        ready_d = (state_d == S_IDLE) && (tiles_d < MAX_TILES);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            stagger_q   <= 1'b0;
            issue_cnt_q <= '0;
            rx_cnt_q    <= '0;
            push_q      <= 1'b0;
            data_q      <= '0;
            tiles_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stagger_q   <= stagger_d;
            issue_cnt_q <= issue_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            push_q      <= push_d;
            data_q      <= data_d;
            tiles_q     <= tiles_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    // Per-tile stagger flag queue, written when a tile completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            queue_q <= '0;
        end else if (complete) begin
            queue_q[wr_ptr_q] <= stagger_q;
        end
    end

    // Output mapping
    always_comb begin
        cmd_ready    = ready_q;
        mem_rd_en    = (state_q == S_ISSUE);
        mem_addr     = addr_q;
        fifo_push    = push_q;
        fifo_data    = data_q;
        tile_ready   = (tiles_q != '0);
        head_stagger = (tiles_q != '0) && queue_q[rd_ptr_q];
        tiles_avail  = tiles_q;
        busy         = (state_q != S_IDLE);
        err          = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_fifo_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_weight_fifo_loader
//  Purpose  : Self-checking bench for weight_fifo_loader with a latency-
//             configurable memory responder and a queue model of tiles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_weight_fifo_loader;

    localparam int FW = 16;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int DT = 4;
    localparam int RW = FW * DW;
    localparam int TW = $clog2(DT + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_stagger = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_valid = 1'b0;
    logic [RW-1:0] mem_rd_data = '0;
    logic          fifo_push;
    logic [RW-1:0] fifo_data;
    logic          tile_ready;
    logic          head_stagger;
    logic          tile_consumed = 1'b0;
    logic [TW-1:0] tiles_avail;
    logic          busy;
    logic [1:0]    err;

    weight_fifo_loader #(
        .FIFO_WIDTH (FW),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH_TILES(DT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_stagger  (cmd_stagger),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .fifo_push    (fifo_push),
        .fifo_data    (fifo_data),
        .tile_ready   (tile_ready),
        .head_stagger (head_stagger),
        .tile_consumed(tile_consumed),
        .tiles_avail  (tiles_avail),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [RW-1:0] data;
    } resp_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    int            lat    = 2;
    bit            consume_at_last = 1'b0;
    resp_t         resp_q[$];
    logic [AW-1:0] addr_log[$];
    logic [RW-1:0] sent_log[$];
    logic [RW-1:0] push_log[$];
    bit            stg_model[$];

    // All outputs packed together, for the reset checks
    function automatic logic [154:0] all_outputs();
        return {cmd_ready, mem_rd_en, mem_addr, fifo_push, fifo_data,
                tile_ready, head_stagger, tiles_avail, busy, err};
    endfunction

    // One clock cycle: memory responder, output logging, then the edge
    task automatic cycle();
        resp_t r;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            r            = resp_q.pop_front();
            mem_rd_valid = 1'b1;
            mem_rd_data  = r.data;
        end
        if (mem_rd_en) begin
            addr_log.push_back(mem_addr);
            r.due  = cyc + lat;
            r.data = {$urandom, $urandom, $urandom, $urandom};
            resp_q.push_back(r);
            sent_log.push_back(r.data);
        end
        if (fifo_push) begin
            push_log.push_back(fifo_data);
            if (consume_at_last && push_log.size() == FW) tile_consumed = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        tile_consumed = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        tile_consumed = 1'b0;
        mem_rd_valid = 1'b0;
        resp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
        stg_model.delete();
    endtask

    // Issue one load and run it to completion; report address/data deviations
    task automatic load_tile(input logic [AW-1:0] base, input logic stg, input int l,
                             output int bad_addr, output int bad_data, output int n_push);
        int            n;
        logic [AW-1:0] e;
        lat = l;
        addr_log.delete();
        sent_log.delete();
        push_log.delete();
        cmd_addr    = base;
        cmd_stagger = stg;
        cmd_valid   = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            cycle();
            n++;
        end
        cycle();
        cmd_valid = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            cycle();
            n++;
        end
        bad_addr = (addr_log.size() == FW) ? 0 : 1;
        for (int i = 0; i < addr_log.size(); i++) begin
            e = base + AW'(i);
            if (addr_log[i] !== e) bad_addr++;
        end
        bad_data = (push_log.size() == sent_log.size()) ? 0 : 1;
        for (int i = 0; i < push_log.size() && i < sent_log.size(); i++) begin
            if (push_log[i] !== sent_log[i]) bad_data++;
        end
        n_push = push_log.size();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_outputs());
        end
        reset = 1'b0;
        cycle();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic();
        int ba, bd, np;
        do_reset();
        checks++;
        if (tiles_avail !== 0) begin
            errors++;
            $display("FAIL basic_tiles_before: got %0d want 0", tiles_avail);
        end
        load_tile(16'h0100, 1'b0, 2, ba, bd, np);
        checks++;
        if (ba !== 0 || bd !== 0 || np !== FW) begin
            errors++;
            $display("FAIL basic_load: bad_addr=%0d bad_data=%0d pushes=%0d want 0/0/%0d", ba, bd, np, FW);
        end
        checks++;
        if (tiles_avail !== 1 || tile_ready !== 1'b1 || head_stagger !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: tiles=%0d ready=%b stagger=%b want 1/1/0", tiles_avail, tile_ready, head_stagger);
        end
    endtask

    task automatic test_fill();
        int ba, bd, np, held;
        bit stg[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load_tile(AW'($urandom), stg[i], $urandom_range(1, 5), ba, bd, np);
            stg_model.push_back(stg[i]);
            checks++;
            if (ba !== 0 || bd !== 0 || tiles_avail !== TW'(stg_model.size())) begin
                errors++;
                $display("FAIL fill_load%0d: bad_addr=%0d bad_data=%0d tiles=%0d want 0/0/%0d", i, ba, bd, tiles_avail, stg_model.size());
            end
        end
        addr_log.delete();
        cmd_valid = 1'b1;
        held = 0;
        repeat (5) begin
            if (cmd_ready !== 1'b0) held++;
            cycle();
        end
        cmd_valid = 1'b0;
        checks++;
        if (held !== 0 || busy !== 1'b0 || addr_log.size() !== 0 || tiles_avail !== 4) begin
            errors++;
            $display("FAIL fill_full: ready_cycles=%0d busy=%b reads=%0d tiles=%0d want 0/0/0/4", held, busy, addr_log.size(), tiles_avail);
        end
        while (stg_model.size() > 0) begin
            checks++;
            if (tile_ready !== 1'b1 || head_stagger !== stg_model[0]) begin
                errors++;
                $display("FAIL fill_head: ready=%b stagger=%b want 1/%b", tile_ready, head_stagger, stg_model[0]);
            end
            void'(stg_model.pop_front());
            tile_consumed = 1'b1;
            cycle();
        end
        checks++;
        if (tile_ready !== 1'b0 || head_stagger !== 1'b0 || tiles_avail !== 0) begin
            errors++;
            $display("FAIL fill_empty: ready=%b stagger=%b tiles=%0d want 0/0/0", tile_ready, head_stagger, tiles_avail);
        end
    endtask

    task automatic test_wrap();
        int ba, bd, np;
        do_reset();
        load_tile(16'hFFF8, 1'b0, 3, ba, bd, np);
        checks++;
        if (ba !== 0 || bd !== 0 || np !== FW) begin
            errors++;
            $display("FAIL wrap_load: bad_addr=%0d bad_data=%0d pushes=%0d want 0/0/%0d", ba, bd, np, FW);
        end
        checks++;
        if (addr_log.size() != FW) begin
            errors++;
            $display("FAIL wrap_count: got %0d reads want %0d", addr_log.size(), FW);
        end else if (addr_log[7] !== 16'hFFFF || addr_log[8] !== 16'h0000 || addr_log[15] !== 16'h0007) begin
            errors++;
            $display("FAIL wrap_addr: got %h/%h/%h want ffff/0000/0007", addr_log[7], addr_log[8], addr_log[15]);
        end
    endtask

    task automatic test_consume_on_last();
        int ba, bd, np;
        do_reset();
        load_tile(16'h1000, 1'b1, 2, ba, bd, np);
        load_tile(16'h2000, 1'b0, 4, ba, bd, np);
        consume_at_last = 1'b1;
        load_tile(16'h3000, 1'b1, 1, ba, bd, np);
        consume_at_last = 1'b0;
        checks++;
        if (np !== FW || tiles_avail !== 2 || head_stagger !== 1'b0) begin
            errors++;
            $display("FAIL overlap_status: pushes=%0d tiles=%0d stagger=%b want %0d/2/0", np, tiles_avail, head_stagger, FW);
        end
        tile_consumed = 1'b1;
        cycle();
        checks++;
        if (tiles_avail !== 1 || head_stagger !== 1'b1) begin
            errors++;
            $display("FAIL overlap_next: tiles=%0d stagger=%b want 1/1", tiles_avail, head_stagger);
        end
    endtask

    task automatic test_errors();
        do_reset();
        tile_consumed = 1'b1;
        cycle();
        checks++;
        if (err !== 2'b01 || tiles_avail !== 0) begin
            errors++;
            $display("FAIL err_underflow: err=%b tiles=%0d want 01/0", err, tiles_avail);
        end
        mem_rd_valid = 1'b1;
        mem_rd_data  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        mem_rd_valid = 1'b0;
        checks++;
        if (fifo_push !== 1'b0 || err !== 2'b11) begin
            errors++;
            $display("FAIL err_idle_rd: push=%b err=%b want 0/11", fifo_push, err);
        end
    endtask

    task automatic test_mid_reset();
        int ba, bd, np, n;
        do_reset();
        lat = 3;
        cmd_addr    = 16'h2000;
        cmd_stagger = 1'b1;
        cmd_valid   = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        n = 0;
        while (!(mem_rd_en && mem_addr == 16'h2007) && n < 50) begin
            cycle();
            n++;
        end
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 16'h2007) begin
            errors++;
            $display("FAIL midrst_reach: rd_en=%b addr=%h want 1/2007", mem_rd_en, mem_addr);
        end
        reset = 1'b1;
        mem_rd_valid = 1'b0;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++;
            $display("FAIL midrst_async: got %h want 0", all_outputs());
        end
        resp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
        checks++;
        if (err !== 2'b00 || tiles_avail !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: err=%b tiles=%0d busy=%b want 00/0/0", err, tiles_avail, busy);
        end
        load_tile(16'h3000, 1'b0, 2, ba, bd, np);
        checks++;
        if (ba !== 0 || bd !== 0 || np !== FW || tiles_avail !== 1 || head_stagger !== 1'b0) begin
            errors++;
            $display("FAIL midrst_reload: bad_addr=%0d bad_data=%0d pushes=%0d tiles=%0d stagger=%b want 0/0/%0d/1/0",
                     ba, bd, np, tiles_avail, head_stagger, FW);
        end
    endtask

    task automatic test_random();
        int ba, bd, np;
        bit s;
        do_reset();
        repeat (16) begin
            if (stg_model.size() < DT && (stg_model.size() == 0 || $urandom_range(0, 2) != 0)) begin
                s = 1'($urandom_range(0, 1));
                load_tile(AW'($urandom), s, $urandom_range(1, 6), ba, bd, np);
                stg_model.push_back(s);
                checks++;
                if (ba !== 0 || bd !== 0 || tiles_avail !== TW'(stg_model.size())) begin
                    errors++;
                    $display("FAIL rand_load: bad_addr=%0d bad_data=%0d tiles=%0d want 0/0/%0d", ba, bd, tiles_avail, stg_model.size());
                end
            end else begin
                checks++;
                if (head_stagger !== stg_model[0] || tile_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_head: stagger=%b ready=%b want %b/1", head_stagger, tile_ready, stg_model[0]);
                end
                void'(stg_model.pop_front());
                tile_consumed = 1'b1;
                cycle();
                checks++;
                if (tiles_avail !== TW'(stg_model.size())) begin
                    errors++;
                    $display("FAIL rand_consume: tiles=%0d want %0d", tiles_avail, stg_model.size());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_consume_on_last();
        test_errors();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
